// File: rtl/unidade_de_busca_pkg.sv
// Shared definitions for the instruction fetch unit and the control logic:
// opcodes, fetch state encoding and execution step constants.
package unidade_de_busca_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NAN = 3'b010;
  localparam logic [2:0] OP_HLT = 3'b011;
  localparam logic [2:0] OP_OUT = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_BEZ = 3'b110;
  localparam logic [2:0] OP_REP = 3'b111;

  typedef enum logic [1:0] {
    ST_FETCH_I = 2'b00,
    ST_FETCH_M = 2'b01,
    ST_EXEC    = 2'b10,
    ST_HALT    = 2'b11
  } state_t;

  localparam logic [1:0] STEP_0 = 2'b00;
  localparam logic [1:0] STEP_1 = 2'b01;
  localparam logic [1:0] STEP_2 = 2'b10;
  localparam logic [1:0] STEP_3 = 2'b11;

  function automatic logic [2:0] opcode_of(input logic [8:0] word);
    return word[8:6];
  endfunction

endpackage

// File: rtl/unidade_de_busca_contador_de_programa.sv
// Program counter: holds the address of the current instruction and advances
// past the instruction/immediate pair or jumps to a branch target.
module contador_de_programa
  import unidade_de_busca_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              load,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next
);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_d;

  // Next PC selection; the adder wraps naturally at ADDR_W bits.
  always_comb begin
    pc_d = pc_r;
    if (load) begin
      if (branch_taken) begin
        pc_d = target;
      end else begin
        pc_d = pc_r + ADDR_W'(2);
      end
    end else begin
      pc_d = pc_r;
    end
  end

  // PC register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_d;
    end
  end

  assign pc      = pc_r;
  assign pc_next = pc_d;

endmodule

// File: rtl/unidade_de_busca.sv
// Instruction fetch unit: fetches instruction and immediate words, sequences
// three execution steps, updates the PC and stops on HLT.
module unidade_de_busca
  import unidade_de_busca_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              resetn,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [8:0]        mem_rdata,
  output logic [1:0]        counter,
  output logic [8:0]        iin,
  output logic [8:0]        imm_out,
  input  logic              pc_wr_enable,
  input  logic              branch_select,
  input  logic              cond_zero,
  output logic              halted
);

  state_t            state_r, state_d;
  logic [1:0]        counter_r, counter_d;
  logic [8:0]        iin_r, iin_d;
  logic [8:0]        imm_r, imm_d;
  logic              halted_r, halted_d;
  logic              mem_req_r, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_d;
  logic [ADDR_W-1:0] pc_s, pc_next_s, target_s;
  logic              handshake_s, pc_load_s, branch_taken_s;

  assign handshake_s    = mem_req_r & mem_ack;
  assign pc_load_s      = (state_r == ST_EXEC) && (counter_r == STEP_3) && pc_wr_enable;
  assign branch_taken_s = branch_select & cond_zero;
  assign target_s       = ADDR_W'(imm_r);

  contador_de_programa #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clock        (clock),
    .resetn       (resetn),
    .load         (pc_load_s),
    .branch_taken (branch_taken_s),
    .target       (target_s),
    .pc           (pc_s),
    .pc_next      (pc_next_s)
  );

  // Next state, step counter and fetch capture.
  always_comb begin
    state_d   = state_r;
    counter_d = counter_r;
    iin_d     = iin_r;
    imm_d     = imm_r;
    case (state_r)
      ST_FETCH_I: begin
        counter_d = STEP_0;
        if (handshake_s) begin
          iin_d = mem_rdata;
          if (opcode_of(mem_rdata) == OP_HLT) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_FETCH_M;
          end
        end else begin
          state_d = ST_FETCH_I;
        end
      end
      ST_FETCH_M: begin
        if (handshake_s) begin
          imm_d     = mem_rdata;
          state_d   = ST_EXEC;
          counter_d = STEP_1;
        end else begin
          state_d   = ST_FETCH_M;
          counter_d = STEP_0;
        end
      end
      ST_EXEC: begin
        if (counter_r == STEP_3) begin
          state_d   = ST_FETCH_I;
          counter_d = STEP_0;
        end else begin
          state_d   = ST_EXEC;
          counter_d = counter_r + 2'd1;
        end
      end
      ST_HALT: begin
        state_d   = ST_HALT;
        counter_d = STEP_0;
      end
      default: begin
        state_d   = ST_FETCH_I;
        counter_d = STEP_0;
      end
    endcase
  end

  // Memory interface outputs are registered, so they are derived from the next state.
  always_comb begin
    mem_req_d  = (state_d == ST_FETCH_I) || (state_d == ST_FETCH_M);
    halted_d   = (state_d == ST_HALT);
    mem_addr_d = mem_addr_r;
    if (state_d == ST_FETCH_M) begin
      mem_addr_d = pc_s + ADDR_W'(1);
    end else if (state_d == ST_FETCH_I) begin
      mem_addr_d = pc_next_s;
    end else begin
      mem_addr_d = mem_addr_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_FETCH_I;
      counter_r  <= STEP_0;
      iin_r      <= 9'h000;
      imm_r      <= 9'h000;
      halted_r   <= 1'b0;
      mem_req_r  <= 1'b0;
      mem_addr_r <= RESET_PC;
    end else begin
      state_r    <= state_d;
      counter_r  <= counter_d;
      iin_r      <= iin_d;
      imm_r      <= imm_d;
      halted_r   <= halted_d;
      mem_req_r  <= mem_req_d;
      mem_addr_r <= mem_addr_d;
    end
  end

  assign mem_req  = mem_req_r;
  assign mem_addr = mem_addr_r;
  assign counter  = counter_r;
  assign iin      = iin_r;
  assign imm_out  = imm_r;
  assign halted   = halted_r;

endmodule

// File: tb/tb_unidade_de_busca.sv
// Randomized self-checking bench for unidade_de_busca against an
// instruction-level model of fetch, execute steps and PC update.
module tb_unidade_de_busca;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [8:0] mem_rdata = 9'h000;
  logic [1:0] counter;
  logic [8:0] iin;
  logic [8:0] imm_out;
  logic       pc_wr_enable = 1'b0;
  logic       branch_select = 1'b0;
  logic       cond_zero = 1'b0;
  logic       halted;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] mem [0:255];
  logic [7:0] pc_model = 8'h00;

  unidade_de_busca #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .counter       (counter),
    .iin           (iin),
    .imm_out       (imm_out),
    .pc_wr_enable  (pc_wr_enable),
    .branch_select (branch_select),
    .cond_zero     (cond_zero),
    .halted        (halted)
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] rand_word();
    logic [8:0] w;
    w = 9'($urandom);
    if (w[8:6] == 3'b011) w[8:6] = 3'b100;
    return w;
  endfunction

  // Serve one memory word after 'waits' idle cycles; the bus must hold steady meanwhile.
  task automatic fetch_word(input string tag, input logic [7:0] a, input int waits);
    for (int i = 0; i <= waits; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== a || counter !== 2'b00 || halted !== 1'b0) begin
        errors++;
        $display("FAIL %s: req=%b addr=%h cnt=%b halted=%b, expected req=1 addr=%h cnt=00 halted=0",
                 tag, mem_req, mem_addr, counter, halted, a);
      end
      mem_ack   = (i == waits);
      mem_rdata = mem_ack ? mem[a] : 9'($urandom);
      @(negedge clock);
    end
    mem_ack   = 1'b0;
    mem_rdata = 9'($urandom);
  endtask

  // One full instruction: two fetches, three execute steps, then the model's PC update.
  task automatic run_instr(input int wait_i, input int wait_m, input logic wr,
                           input logic bsel, input logic cz);
    logic [8:0] wi, wm;
    logic [7:0] a;
    a  = pc_model;
    wi = mem[a];
    fetch_word("fetch_instr", a, wait_i);
    a  = pc_model + 8'd1;
    wm = mem[a];
    fetch_word("fetch_imm", a, wait_m);
    for (int s = 1; s <= 3; s++) begin
      checks++;
      if (counter !== 2'(s) || mem_req !== 1'b0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL exec_step: cnt=%b req=%b halted=%b, expected cnt=%0d req=0 halted=0",
                 counter, mem_req, halted, s);
      end
      checks++;
      if (iin !== wi || imm_out !== wm) begin
        errors++;
        $display("FAIL exec_words: iin=%h imm=%h, expected iin=%h imm=%h", iin, imm_out, wi, wm);
      end
      if (s == 3) begin
        pc_wr_enable = wr; branch_select = bsel; cond_zero = cz;
      end else begin
        pc_wr_enable = 1'($urandom); branch_select = 1'($urandom); cond_zero = 1'($urandom);
      end
      @(negedge clock);
    end
    pc_wr_enable = 1'b0; branch_select = 1'b0; cond_zero = 1'b0;
    if (wr) pc_model = (bsel && cz) ? wm[7:0] : pc_model + 8'd2;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0; mem_ack = 1'b0;
    pc_wr_enable = 1'b0; branch_select = 1'b0; cond_zero = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    pc_model = 8'h00;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (mem_req !== 1'b0 || counter !== 2'b00 || iin !== 9'h000 || imm_out !== 9'h000 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: req=%b cnt=%b iin=%h imm=%h halted=%b, expected all zero",
               mem_req, counter, iin, imm_out, halted);
    end
    resetn = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: req=%b, expected 0 before first clock", mem_req);
    end
    @(negedge clock);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
      errors++;
      $display("FAIL first_request: req=%b addr=%h, expected req=1 addr=00", mem_req, mem_addr);
    end
    pc_model = 8'h00;
  endtask

  task automatic test_basic();
    mem[0] = {3'b000, 3'b001, 3'b010};
    mem[1] = 9'h000;
    run_instr(0, 0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (mem_addr !== 8'h02 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL basic_next_pc: addr=%h req=%b, expected addr=02 req=1", mem_addr, mem_req);
    end
  endtask

  task automatic test_wait_states();
    mem[2] = rand_word();
    mem[3] = rand_word();
    run_instr(3, 3, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_branch();
    mem[4]    = {3'b110, 6'($urandom)};
    mem[5]    = 9'h020;
    run_instr(0, 1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (mem_addr !== 8'h20) begin
      errors++;
      $display("FAIL branch_taken: addr=%h, expected 20", mem_addr);
    end
    mem[8'h20] = {3'b110, 6'($urandom)};
    mem[8'h21] = 9'h004;
    run_instr(0, 0, 1'b1, 1'b1, 1'b1);
    run_instr(1, 0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (mem_addr !== 8'h06) begin
      errors++;
      $display("FAIL branch_not_taken: addr=%h, expected 06", mem_addr);
    end
  endtask

  task automatic test_wrap();
    mem[6]     = {3'b110, 6'($urandom)};
    mem[7]     = 9'h0FE;
    run_instr(0, 0, 1'b1, 1'b1, 1'b1);
    mem[8'hFE] = rand_word();
    mem[8'hFF] = rand_word();
    run_instr(0, 2, 1'b1, 1'b0, 1'b1);
    checks++;
    if (mem_addr !== 8'h00) begin
      errors++;
      $display("FAIL pc_wrap: addr=%h, expected 00", mem_addr);
    end
  endtask

  task automatic test_refetch();
    run_instr(0, 0, 1'b0, 1'b1, 1'b1);
    run_instr(1, 1, 1'b0, 1'b0, 1'b0);
    run_instr(0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) mem[i] = rand_word();
    for (int n = 0; n < 40; n++) begin
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_fetch();
    fetch_word("pre_reset_fetch", pc_model, 0);
    @(negedge clock);
    mem_ack = 1'b1;
    resetn  = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || counter !== 2'b00 || iin !== 9'h000 || imm_out !== 9'h000 || halted !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: req=%b cnt=%b iin=%h imm=%h halted=%b, expected all zero",
               mem_req, counter, iin, imm_out, halted);
    end
    @(negedge clock);
    checks++;
    if (mem_req !== 1'b0 || imm_out !== 9'h000) begin
      errors++;
      $display("FAIL late_ack_in_reset: req=%b imm=%h, expected req=0 imm=000", mem_req, imm_out);
    end
    mem_ack = 1'b0;
    resetn  = 1'b1;
    @(negedge clock);
    pc_model = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = rand_word();
    run_instr(0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_halt();
    logic [8:0] hw;
    do_reset();
    mem[0] = rand_word();
    mem[1] = rand_word();
    hw     = {3'b011, 6'($urandom)};
    mem[2] = hw;
    run_instr(int'($urandom_range(0, 2)), 0, 1'b1, 1'b0, 1'b0);
    fetch_word("fetch_hlt", pc_model, 1);
    checks++;
    if (halted !== 1'b1 || mem_req !== 1'b0 || counter !== 2'b00 || iin !== hw) begin
      errors++;
      $display("FAIL halt_entry: halted=%b req=%b cnt=%b iin=%h, expected halted=1 req=0 cnt=00 iin=%h",
               halted, mem_req, counter, iin, hw);
    end
    for (int i = 0; i < 20; i++) begin
      mem_ack = 1'($urandom); mem_rdata = 9'($urandom);
      pc_wr_enable = 1'($urandom); branch_select = 1'($urandom); cond_zero = 1'($urandom);
      @(negedge clock);
      checks++;
      if (halted !== 1'b1 || mem_req !== 1'b0 || counter !== 2'b00 || iin !== hw) begin
        errors++;
        $display("FAIL halt_hold: cycle=%0d halted=%b req=%b cnt=%b iin=%h, expected 1 0 00 %h",
                 i, halted, mem_req, counter, iin, hw);
      end
    end
    mem_ack = 1'b0; pc_wr_enable = 1'b0; branch_select = 1'b0; cond_zero = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 9'h000;
    test_reset();
    test_basic();
    test_wait_states();
    test_branch();
    test_wrap();
    test_refetch();
    test_random();
    test_reset_mid_fetch();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidade_de_busca.md
UNIDADE_DE_BUSCA -- requirements
Module: unidade_de_busca

Interface
REQ-001 Parameter: ADDR_W, default 8, width of program address and PC.
REQ-002 Parameter: RESET_PC, default 0, PC value loaded on reset.
REQ-003 Port: clock, input, 1, single clock; all state updates on rising edge.
REQ-004 Port: resetn, input, 1, reset; asynchronous, active-low.
REQ-005 Port: mem_req, output, 1, fetch request to program memory.
REQ-006 Port: mem_addr, output, ADDR_W, word address of the current request.
REQ-007 Port: mem_ack, input, 1, memory acknowledge; the word is transferred on a cycle where mem_req and mem_ack are both high.
REQ-008 Port: mem_rdata, input, 9, memory word; valid when mem_ack is high.
REQ-009 Port: counter, output, 2, instruction step count driven to the control logic.
REQ-010 Port: iin, output, 9, current instruction word: opcode [8:6], rx [5:3], ry [2:0].
REQ-011 Port: imm_out, output, 9, immediate word that follows the instruction.
REQ-012 Port: pc_wr_enable, input, 1, PC update strobe from the control logic.
REQ-013 Port: branch_select, input, 1, high when the current instruction is BEZ.
REQ-014 Port: cond_zero, input, 1, high when the BEZ operand is zero.
REQ-015 Port: halted, output, 1, high once HLT has been fetched.

Function
REQ-016 Each instruction occupies two words: the instruction at PC and the immediate at PC+1 (mod 2^ADDR_W).
REQ-017 The state machine has four states: FETCH_I, FETCH_M, EXEC and HALT.
REQ-018 FETCH_I: mem_req=1 and mem_addr=PC; on handshake, capture iin and go to FETCH_M.
REQ-019 FETCH_I transition on handshake: if mem_rdata[8:6]==3'b011 (HLT), go to HALT instead of FETCH_M.
REQ-020 FETCH_M: mem_req=1 and mem_addr=PC+1; on handshake, capture imm_out and go to EXEC.
REQ-021 While mem_ack is low, mem_req and mem_addr remain stable; there is no timeout.
REQ-022 A combinational same-cycle mem_ack is legal, so the minimum fetch time is 1 cycle per word.
REQ-023 Counter in FETCH_I and FETCH_M: counter holds at 2'b00.
REQ-024 Counter in EXEC: counter steps 00->01->10->11, one step per clock.
REQ-025 After 11, the state returns to FETCH_I with counter 00.
REQ-026 Minimum cycles per instruction: 2 fetch cycles plus 3 EXEC cycles.
REQ-027 mem_req is 0 in EXEC and HALT.
REQ-028 iin and imm_out hold their values from capture until the next capture of the same register.
REQ-029 PC update: only in EXEC, at counter==11 with pc_wr_enable==1.
REQ-030 Branch: if branch_select && cond_zero, PC <= imm_out[ADDR_W-1:0]; otherwise PC <= PC+2.
REQ-031 PC arithmetic wraps modulo 2^ADDR_W (e.g. 8'hFF+2 = 8'h01).
REQ-032 If pc_wr_enable==0 at counter 11, PC holds and the same instruction is refetched.
REQ-033 HALT: halted=1, counter holds at 00, mem_req=0, PC frozen; only reset exits HALT.
REQ-034 The HLT instruction never reaches EXEC.
REQ-035 branch_select and cond_zero are ignored outside counter 11.

Reset
REQ-036 Reset is asynchronous on resetn low: state=FETCH_I, PC=RESET_PC, counter=00, iin=0, imm_out=0, halted=0, mem_req=0.
REQ-037 mem_req is asserted from the first clock after resetn deasserts.
REQ-038 Reset mid-fetch abandons the outstanding request; a late mem_ack while reset is active is ignored.

Structure
REQ-039 A shared package holds the opcode constants (ADD, SUB, NAN, HLT, OUT, LDI, BEZ, REP), the state encodings and the counter step constants; the control logic uses the same package.
REQ-040 A single sub-module, contador_de_programa (PC register with branch and increment mux), is used; the FSM and the fetch registers stay in the top module.

Verification
REQ-041 Reset, then zero-wait memory holding ADD at addr 0 and 0 at addr 1 -> fetch addresses 0,1; counter 00,01,10,11; PC=2; next mem_addr=2.
REQ-042 mem_ack delayed 3 cycles on each word -> mem_addr held, counter stays 00 for 8 cycles, then iin and imm_out are correct.
REQ-043 BEZ at addr 4 with imm 9'h020, cond_zero=1 at counter 11 -> PC=8'h20; with cond_zero=0 -> PC=6.
REQ-044 Instruction at 8'hFE -> immediate fetched at 8'hFF; next PC=8'h00.
REQ-045 HLT word at addr 2 -> halted=1, mem_req=0, and no further fetch for 20 cycles.
REQ-046 resetn low while waiting in FETCH_M -> all outputs at reset values immediately; on release, fetch restarts at RESET_PC.
